// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store controller for the RV32I five-stage pipeline.
// Latency: a store stalls for 2 cycles and a load for 3; each cycle gnt or rvalid is late adds one.
// Backpressure: request fields are held until dm_gnt_i. stall_o holds IF/ID/EX and EX/MEM until DONE.
//
// Ports:
//   clk, rst                 - pipeline clock, synchronous active-high reset
//   mem_read_ctrl_i          - load request from EX/MEM (takes priority over a store)
//   mem_write_ctrl_i         - store request from EX/MEM
//   wr_width_i               - funct3 access width (B/H/W/BU/HU)
//   alu_dataCaddress_i       - byte address
//   w_data_i                 - store data (low bits significant)
//   dm_req_o/we/addr/be/wdata- registered data-memory request
//   dm_gnt_i                 - memory accepted the request this cycle
//   dm_rvalid_i/dm_rdata_i   - read response
//   load_data_o              - extended load result, held until the next load completes
//   load_valid_o             - one-cycle pulse in the cycle a load completes
//   stall_o                  - pipeline hold (combinational)
//   misalign_o               - access rejected (combinational)
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_ctrl_i,
  input  logic        mem_write_ctrl_i,
  input  logic [2:0]  wr_width_i,
  input  logic [31:0] alu_dataCaddress_i,
  input  logic [31:0] w_data_i,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [3:0]  dm_be_o,
  output logic [31:0] dm_wdata_o,
  input  logic        dm_gnt_i,
  input  logic        dm_rvalid_i,
  input  logic [31:0] dm_rdata_i,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        stall_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;

  // Width and offset of the access in flight; needed to pick the lane out
  // of the returned word after EX/MEM inputs may no longer be trusted.
  logic [2:0]  width_q;
  logic [1:0]  off_q;
  logic        is_load_q;

  logic        access_vld;
  logic        is_load;
  logic [1:0]  off;
  logic        width_ok;
  logic        legal;
  logic        start;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] rdata_sh;
  logic [31:0] load_ext;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  assign access_vld = mem_read_ctrl_i | mem_write_ctrl_i;
  assign is_load    = mem_read_ctrl_i;   // read wins when both are asserted
  assign off        = alu_dataCaddress_i[1:0];

  always_comb begin
    width_ok = 1'b0;
    unique case (wr_width_i)
      3'b000, 3'b100: width_ok = 1'b1;
      3'b001, 3'b101: width_ok = ~off[0];
      3'b010:         width_ok = (off == 2'b00);
      default:        width_ok = 1'b0;
    endcase
  end

  // Stores have no unsigned variants, so bit 2 of the width must be clear.
  assign legal = width_ok & (is_load | ~wr_width_i[2]);
  assign start = (state_q == IDLE) & access_vld & legal;

  assign misalign_o = (state_q == IDLE) & access_vld & ~legal;
  assign stall_o    = start | (state_q == REQ) | (state_q == WAIT);

  // Byte enables and lane-replicated store data. Replication lets the memory
  // take the lane selected by dm_be_o without needing its own shifter.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = w_data_i;
    if (!is_load) begin
      unique case (wr_width_i[1:0])
        2'b00: begin
          be_d    = 4'b0001 << off;
          wdata_d = {4{w_data_i[7:0]}};
        end
        2'b01: begin
          be_d    = 4'b0011 << off;
          wdata_d = {2{w_data_i[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = w_data_i;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Load lane extraction from the returned word
  // ---------------------------------------------------------------------------
  assign rdata_sh = dm_rdata_i >> {off_q, 3'b000};

  always_comb begin
    load_ext = rdata_sh;
    unique case (width_q)
      3'b000:  load_ext = {{24{rdata_sh[7]}},  rdata_sh[7:0]};
      3'b100:  load_ext = {24'h000000,         rdata_sh[7:0]};
      3'b001:  load_ext = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      3'b101:  load_ext = {16'h0000,           rdata_sh[15:0]};
      default: load_ext = rdata_sh;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start)       state_d = REQ;
      REQ:  if (dm_gnt_i)    state_d = is_load_q ? WAIT : DONE;
      WAIT: if (dm_rvalid_i) state_d = DONE;
      // EX/MEM advances on this edge, so the finished access is not reissued.
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      width_q      <= 3'b000;
      off_q        <= 2'b00;
      is_load_q    <= 1'b0;
      dm_req_o     <= 1'b0;
      dm_we_o      <= 1'b0;
      dm_addr_o    <= 32'h0;
      dm_be_o      <= 4'h0;
      dm_wdata_o   <= 32'h0;
      load_data_o  <= 32'h0;
      load_valid_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_valid_o <= 1'b0;

      if (start) begin
        dm_req_o   <= 1'b1;
        dm_we_o    <= ~is_load;
        dm_addr_o  <= {alu_dataCaddress_i[31:2], 2'b00};
        dm_be_o    <= be_d;
        dm_wdata_o <= wdata_d;
        width_q    <= wr_width_i;
        off_q      <= off;
        is_load_q  <= is_load;
      end

      if ((state_q == REQ) && dm_gnt_i) begin
        dm_req_o <= 1'b0;
      end

      // load_valid_o is registered here so it is high exactly in DONE.
      if ((state_q == WAIT) && dm_rvalid_i) begin
        load_data_o  <= load_ext;
        load_valid_o <= 1'b1;
      end
    end
  end

endmodule
